// File: rtl/nr_divmod_param.sv
`default_nettype none
// ============================================================================
// Module   : nr_divmod_param
// Brief    : Iterative non-restoring signed/unsigned divider, quotient or
//            remainder on result, divide-by-zero flag, ready/valid on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module nr_divmod_param #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic                  mode,
    input  logic                  signed_op,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] result,
    output logic                  div_by_zero,
    output logic                  valid_out,
    input  logic                  ready_out
);

    localparam int c_pw    = DIVISOR_W + 1;
    localparam int c_tw    = DIVISOR_W + 2;
    localparam int c_cnt_w = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(DIVIDEND_W - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_fix  = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    logic [1:0]            r_state;
    logic                  r_mode;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic [DIVIDEND_W-1:0] r_dmag;
    logic [DIVISOR_W-1:0]  r_dvs;
    logic [c_pw-1:0]       r_p;
    logic [DIVIDEND_W-1:0] r_q;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [DIVIDEND_W-1:0] r_result;
    logic                  r_dbz;
    logic                  r_valid;

    logic                  w_accept;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DIVIDEND_W-1:0] w_a_mag;
    logic [DIVISOR_W-1:0]  w_b_mag;
    logic [c_tw-1:0]       w_ext;
    logic [c_tw-1:0]       w_d;
    logic [c_tw-1:0]       w_new;
    logic [c_pw-1:0]       w_p_next;
    logic                  w_qbit;
    logic [DIVISOR_W-1:0]  w_rem_mag;
    logic [DIVIDEND_W-1:0] w_rem_ext;
    logic [DIVIDEND_W-1:0] w_rem_out;
    logic [DIVIDEND_W-1:0] w_quo;

    assign ready_in    = (r_state == c_idle) & ~reset;
    assign w_accept    = valid_in & ready_in;
    assign result      = r_result;
    assign div_by_zero = r_dbz;
    assign valid_out   = r_valid;

    assign w_a_neg = signed_op & dividend[DIVIDEND_W-1];
    assign w_b_neg = signed_op & divisor[DIVISOR_W-1];
    assign w_a_mag = w_a_neg ? -dividend : dividend;
    assign w_b_mag = w_b_neg ? -divisor : divisor;

    // One extra guard bit: the shifted remainder spans [-2D, 2D) before the add/sub.
    assign w_ext    = {r_p, r_dmag[DIVIDEND_W-1]};
    assign w_d      = {2'b00, r_dvs};
    assign w_new    = r_p[c_pw-1] ? (w_ext + w_d) : (w_ext - w_d);
    assign w_p_next = w_new[c_pw-1:0];
    assign w_qbit   = ~w_new[c_tw-1];

    assign w_rem_mag = r_p[c_pw-1] ? (r_p[DIVISOR_W-1:0] + r_dvs) : r_p[DIVISOR_W-1:0];
    assign w_rem_ext = DIVIDEND_W'(w_rem_mag);
    assign w_rem_out = r_neg_r ? -w_rem_ext : w_rem_ext;
    assign w_quo     = r_neg_q ? -r_q : r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_idle;
            r_mode   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dmag   <= '0;
            r_dvs    <= '0;
            r_p      <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_dbz    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_mode  <= mode;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_dmag  <= w_a_mag;
                        r_dvs   <= w_b_mag;
                        r_p     <= '0;
                        r_q     <= '0;
                        r_cnt   <= c_cnt_init;
                        if (divisor == '0) begin
                            r_result <= mode ? dividend : '1;
                            r_dbz    <= 1'b1;
                            r_state  <= c_done;
                        end else begin
                            r_state  <= c_calc;
                        end
                    end
                end
                c_calc: begin
                    r_p    <= w_p_next;
                    r_q    <= {r_q[DIVIDEND_W-2:0], w_qbit};
                    r_dmag <= r_dmag << 1;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= c_fix;
                    end
                end
                c_fix: begin
                    r_result <= r_mode ? w_rem_out : w_quo;
                    r_dbz    <= 1'b0;
                    r_state  <= c_done;
                end
                c_done: begin
                    // valid_out is raised one cycle after entering DONE
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                    end else if (ready_out) begin
                        r_valid <= 1'b0;
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nr_divmod_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_nr_divmod_param
// Brief    : Directed and randomised scoreboard bench for nr_divmod_param.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nr_divmod_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, ready_in, mode, signed_op;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic [31:0] result;
    logic        div_by_zero, valid_out, ready_out;

    logic        valid_in8, ready_in8, mode8, signed8;
    logic [7:0]  dividend8, divisor8, result8;
    logic        dbz8, valid_out8, ready_out8;

    always #5 clk = ~clk;

    nr_divmod_param dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .mode(mode), .signed_op(signed_op), .dividend(dividend), .divisor(divisor),
        .result(result), .div_by_zero(div_by_zero), .valid_out(valid_out),
        .ready_out(ready_out)
    );

    nr_divmod_param #(.DIVIDEND_W(8), .DIVISOR_W(8)) dut8 (
        .clk(clk), .reset(reset), .valid_in(valid_in8), .ready_in(ready_in8),
        .mode(mode8), .signed_op(signed8), .dividend(dividend8), .divisor(divisor8),
        .result(result8), .div_by_zero(dbz8), .valid_out(valid_out8),
        .ready_out(ready_out8)
    );

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int          lat;
        int          t_acc;
    } exp_t;

    exp_t        scb[$];
    logic [7:0]  scb8[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic m, input logic s,
                                          input logic [31:0] a, input logic [15:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = {{16{b[15]}}, b};
        if (b == 16'd0) return m ? a : 32'hFFFF_FFFF;
        if (s) return m ? 32'(sa % sb) : 32'(sa / sb);
        return m ? (a % {16'h0, b}) : (a / {16'h0, b});
    endfunction

    task automatic issue(input logic m, input logic s, input logic [31:0] a,
                         input logic [15:0] b, input logic [31:0] er,
                         input logic ed, input int el);
        int n = 0;
        @(negedge clk);
        while (!ready_in && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_in_wait", {31'd0, ready_in}, 32'd1);
        mode = m; signed_op = s; dividend = a; divisor = b; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        scb.push_back('{er, ed, el, cyc});
        @(negedge clk);
        chk("ready_in_busy", {31'd0, ready_in}, 32'd0);
    endtask

    task automatic collect(input int hold);
        int   n = 0;
        exp_t e;
        logic [31:0] held;
        while (!valid_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("valid_out_seen", {31'd0, valid_out}, 32'd1);
        e = scb.pop_front();
        chk("result", result, e.res);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        chk("latency", 32'(cyc - e.t_acc), 32'(e.lat));
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_result", result, held);
            chk("bp_valid", {31'd0, valid_out}, 32'd1);
            chk("bp_ready_in", {31'd0, ready_in}, 32'd0);
        end
        ready_out = 1'b1;
        @(negedge clk);
        chk("valid_out_consumed", {31'd0, valid_out}, 32'd0);
        chk("ready_in_after", {31'd0, ready_in}, 32'd1);
    endtask

    initial begin
        logic        rm, rs;
        logic [31:0] ra;
        logic [15:0] rb;
        int          n;

        reset = 1'b1; valid_in = 1'b0; mode = 1'b0; signed_op = 1'b0;
        dividend = '0; divisor = '0; ready_out = 1'b1;
        valid_in8 = 1'b0; mode8 = 1'b0; signed8 = 1'b0;
        dividend8 = '0; divisor8 = '0; ready_out8 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready_in", {31'd0, ready_in}, 32'd0);
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        reset = 1'b0;
        #1 chk("rel_ready_in", {31'd0, ready_in}, 32'd1);

        // Unsigned quotient, then back-to-back remainders
        issue(0, 0, 32'd537133248, 16'd25347, 32'd21191, 0, 34); collect(0);
        issue(1, 0, 32'd690275523, 16'd25443, 32'd6933, 0, 34);  collect(0);
        issue(1, 0, 32'd21, 16'd5, 32'd1, 0, 34);                 collect(0);

        // Signed truncating semantics
        issue(0, 1, 32'hFFFF_FFEB, 16'd5, 32'hFFFF_FFFC, 0, 34);      collect(0);
        issue(1, 1, 32'hFFFF_FFEB, 16'd5, 32'hFFFF_FFFF, 0, 34);      collect(0);
        issue(0, 1, 32'd21, 16'hFFFB, 32'hFFFF_FFFC, 0, 34);          collect(0);
        issue(1, 1, 32'd21, 16'hFFFB, 32'd1, 0, 34);                  collect(0);
        issue(0, 1, 32'h8000_0000, 16'hFFFF, 32'h8000_0000, 0, 34);   collect(0);
        issue(1, 1, 32'h8000_0000, 16'hFFFF, 32'd0, 0, 34);           collect(0);

        // Divide by zero
        issue(0, 0, 32'd100, 16'd0, 32'hFFFF_FFFF, 1, 1); collect(0);
        issue(1, 0, 32'd100, 16'd0, 32'd100, 1, 1);       collect(0);

        // Randomised operands against the behavioural model
        for (int k = 0; k < 8; k++) begin
            rm = 1'($urandom); rs = 1'($urandom);
            ra = $urandom; rb = 16'($urandom);
            if (k == 7) rb = 16'd0;
            if (rs && ra == 32'h8000_0000) ra = 32'd1;
            issue(rm, rs, ra, rb, model(rm, rs, ra, rb), (rb == 16'd0), (rb == 16'd0) ? 1 : 34);
            collect(0);
        end

        // Back-pressure: hold the result for ten cycles
        ready_out = 1'b0;
        issue(0, 0, 32'd1000, 16'd7, 32'd142, 0, 34);
        collect(10);

        // Reset mid-CALC aborts without a valid_out pulse
        @(negedge clk);
        mode = 1'b0; signed_op = 1'b0; dividend = 32'd21; divisor = 16'd5; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
        chk("midrst_ready_in", {31'd0, ready_in}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("midrst_rel_ready", {31'd0, ready_in}, 32'd1);
        issue(0, 0, 32'd21, 16'd5, 32'd4, 0, 34); collect(0);

        // 8/8 instance: 255/16 -> quotient 15, remainder 15, latency 10
        for (int m = 0; m < 2; m++) begin
            int t0;
            n = 0;
            @(negedge clk);
            while (!ready_in8 && n < 100) begin
                @(negedge clk);
                n++;
            end
            mode8 = 1'(m); dividend8 = 8'd255; divisor8 = 8'd16; valid_in8 = 1'b1;
            @(posedge clk);
            #1 valid_in8 = 1'b0;
            t0 = cyc;
            scb8.push_back(8'd15);
            n = 0;
            while (!valid_out8 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("w8_valid_seen", {31'd0, valid_out8}, 32'd1);
            chk("w8_result", {24'd0, result8}, {24'd0, scb8.pop_front()});
            chk("w8_latency", 32'(cyc - t0), 32'd10);
            @(negedge clk);
            chk("w8_consumed", {31'd0, valid_out8}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
